// File: rtl/crc16_frame_receiver.sv
// Serial CRC-16 frame receiver: deserialises a 64-bit MSB-first payload and its CRC.
// It checks the LFSR residual and holds the result on a valid/ack handshake.

module crc16_frame_receiver #(
   parameter int          MSG_W    = 64,
   parameter logic [15:0] RESIDUAL = 16'h800D
) (
   input  logic             clk,
   input  logic             rst_L,
   input  logic             i_bit_in,
   input  logic             i_bit_valid,
   input  logic             i_sof,
   input  logic             i_msg_ack,
   output logic             o_msg_valid,
   output logic             o_crc_ok,
   output logic [MSG_W-1:0] o_message,
   output logic             o_busy,
   output logic             o_overrun
);

   localparam int CNT_W = $clog2(MSG_W + 17);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(MSG_W - 1);
   localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(MSG_W + 15);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2,
      HOLD = 2'd3
   } stateT;

   stateT             r_state;
   stateT             w_nextState;
   logic [15:0]       r_lfsr;
   logic [CNT_W-1:0]  r_count;
   logic [MSG_W-1:0]  r_shift;
   logic [MSG_W-1:0]  r_message;
   logic              r_msgValid;
   logic              r_crcOk;
   logic              r_overrun;

   logic              w_accept;
   logic              w_startFrame;
   logic              w_dataBit;
   logic              w_crcBit;
   logic              w_deliver;
   logic              w_release;
   logic              w_setOverrun;
   logic [15:0]       w_lfsrStep;
   logic [15:0]       w_lfsrSeed;

   // x^16 + x^15 + x^2 + 1, MSB first
   function automatic logic [15:0] lfsrStep(input logic [15:0] cur, input logic b);
      logic        fb;
      logic [15:0] nxt;
      fb      = b ^ cur[15];
      nxt     = {cur[14:0], fb};
      nxt[2]  = cur[1] ^ fb;
      nxt[15] = cur[14] ^ fb;
      return nxt;
   endfunction

   assign w_accept   = i_bit_valid;
   assign w_lfsrStep = lfsrStep(r_lfsr, i_bit_in);
   assign w_lfsrSeed = lfsrStep(16'hFFFF, i_bit_in);

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A sof on any accepted bit restarts the frame, except in HOLD where it needs an ack
   always_comb begin
      w_nextState  = r_state;
      w_startFrame = 1'b0;
      w_dataBit    = 1'b0;
      w_crcBit     = 1'b0;
      w_deliver    = 1'b0;
      w_release    = 1'b0;
      w_setOverrun = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && i_sof) begin
               w_startFrame = 1'b1;
               w_nextState  = DATA;
            end
         end
         DATA: begin
            if (w_accept) begin
               if (i_sof) begin
                  w_startFrame = 1'b1;
               end else begin
                  w_dataBit = 1'b1;
                  if (r_count == LAST_DATA) begin
                     w_nextState = CRC;
                  end
               end
            end
         end
         CRC: begin
            if (w_accept) begin
               if (i_sof) begin
                  w_startFrame = 1'b1;
                  w_nextState  = DATA;
               end else begin
                  w_crcBit = 1'b1;
                  if (r_count == LAST_CRC) begin
                     w_deliver   = 1'b1;
                     w_nextState = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (i_msg_ack) begin
               w_release = 1'b1;
               if (w_accept && i_sof) begin
                  w_startFrame = 1'b1;
                  w_nextState  = DATA;
               end else begin
                  w_nextState = IDLE;
               end
            end else if (w_accept && i_sof) begin
               w_setOverrun = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_lfsr  <= 16'hFFFF;
         r_count <= '0;
         r_shift <= '0;
      end else if (w_startFrame) begin
         r_lfsr  <= w_lfsrSeed;
         r_count <= CNT_W'(1);
         r_shift <= {r_shift[MSG_W-2:0], i_bit_in};
      end else if (w_dataBit) begin
         r_lfsr  <= w_lfsrStep;
         r_count <= r_count + CNT_W'(1);
         r_shift <= {r_shift[MSG_W-2:0], i_bit_in};
      end else if (w_crcBit) begin
         r_lfsr  <= w_lfsrStep;
         r_count <= r_count + CNT_W'(1);
      end
   end

   // The check uses the step result so crc_ok is ready on the same edge as msg_valid
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_msgValid <= 1'b0;
         r_crcOk    <= 1'b0;
         r_message  <= '0;
      end else if (w_deliver) begin
         r_msgValid <= 1'b1;
         r_crcOk    <= (w_lfsrStep == RESIDUAL);
         r_message  <= r_shift;
      end else if (w_release) begin
         r_msgValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_overrun <= 1'b0;
      end else if (w_release) begin
         r_overrun <= 1'b0;
      end else if (w_setOverrun) begin
         r_overrun <= 1'b1;
      end
   end

   assign o_msg_valid = r_msgValid;
   assign o_crc_ok    = r_crcOk;
   assign o_message   = r_message;
   assign o_busy      = (r_state == DATA) || (r_state == CRC);
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_crc16_frame_receiver.sv
// Scoreboard bench for crc16_frame_receiver: directed frames drive the link,
// a monitor pops expected messages whenever msg_valid rises.

module tb_crc16_frame_receiver;

   logic        clk;
   logic        rst_L;
   logic        i_bit_in;
   logic        i_bit_valid;
   logic        i_sof;
   logic        i_msg_ack;
   logic        o_msg_valid;
   logic        o_crc_ok;
   logic [63:0] o_message;
   logic        o_busy;
   logic        o_overrun;

   typedef struct {
      logic [63:0] msg;
      logic        ok;
   } expT;

   expT   sbQ[$];
   expT   curExp;
   int    total;
   int    bad;
   int    stallPct;
   logic  prevValid;

   logic [63:0] payA;
   logic [63:0] payB;
   logic [79:0] frameA;
   logic [79:0] frameB;

   crc16_frame_receiver #(
      .MSG_W(64),
      .RESIDUAL(16'h800D)
   ) dut (
      .clk        (clk),
      .rst_L      (rst_L),
      .i_bit_in   (i_bit_in),
      .i_bit_valid(i_bit_valid),
      .i_sof      (i_sof),
      .i_msg_ack  (i_msg_ack),
      .o_msg_valid(o_msg_valid),
      .o_crc_ok   (o_crc_ok),
      .o_message  (o_message),
      .o_busy     (o_busy),
      .o_overrun  (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter reference: polynomial 0x8005, MSB first, init 0xFFFF
   function automatic logic [15:0] modelStep(input logic [15:0] s, input logic b);
      logic [15:0] n;
      n = {s[14:0], 1'b0};
      if (b ^ s[15]) n = n ^ 16'h8005;
      return n;
   endfunction

   function automatic logic [79:0] buildFrame(input logic [63:0] p);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 63; i >= 0; i--) c = modelStep(c, p[i]);
      return {p, ~c};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkMid();
      checkOutput("busyMidFrame", 64'(o_busy), 64'd1);
      checkOutput("earlyValid", 64'(o_msg_valid), 64'd0);
   endtask

   task automatic sendBit(input logic b, input logic s, input logic ack, input bit midCheck);
      while (stallPct > 0 && $urandom_range(99) < stallPct) begin
         @(negedge clk);
         if (midCheck) checkMid();
         i_bit_valid = 1'b0;
         i_sof       = 1'b0;
         i_msg_ack   = 1'b0;
         i_bit_in    = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (midCheck) checkMid();
      i_bit_in    = b;
      i_sof       = s;
      i_msg_ack   = ack;
      i_bit_valid = 1'b1;
   endtask

   task automatic goIdle();
      @(negedge clk);
      i_bit_valid = 1'b0;
      i_sof       = 1'b0;
      i_msg_ack   = 1'b0;
   endtask

   task automatic applyStimulus(input logic [79:0] frame, input int nBits, input bit push,
                                input logic [63:0] expMsg, input logic expOk, input logic ackFirst);
      expT e;
      if (push) begin
         e.msg = expMsg;
         e.ok  = expOk;
         sbQ.push_back(e);
      end
      for (int i = 0; i < nBits; i++) begin
         sendBit(frame[79-i], (i == 0), (i == 0) ? ackFirst : 1'b0, (i > 0));
      end
      if (nBits == 80) begin
         goIdle();
         checkOutput("validLatency", 64'(o_msg_valid), 64'd1);
      end
   endtask

   task automatic applyAck();
      @(negedge clk);
      i_bit_valid = 1'b0;
      i_sof       = 1'b0;
      i_msg_ack   = 1'b1;
      @(negedge clk);
      i_msg_ack = 1'b0;
      checkOutput("validAfterAck", 64'(o_msg_valid), 64'd0);
      checkOutput("overrunAfterAck", 64'(o_overrun), 64'd0);
   endtask

   // Monitor: pop on each rising msg_valid and watch the held message stay put
   always @(negedge clk) begin
      if (!rst_L) begin
         prevValid = 1'b0;
      end else begin
         if (o_msg_valid && !prevValid) begin
            if (sbQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedValid: got message %h expected no message at %0t", o_message, $time);
               curExp.msg = o_message;
               curExp.ok  = o_crc_ok;
            end else begin
               curExp = sbQ.pop_front();
               checkOutput("message", o_message, curExp.msg);
               checkOutput("crcOk", 64'(o_crc_ok), 64'(curExp.ok));
            end
         end else if (o_msg_valid) begin
            checkOutput("heldMessage", o_message, curExp.msg);
            checkOutput("heldCrcOk", 64'(o_crc_ok), 64'(curExp.ok));
         end
         prevValid = o_msg_valid;
      end
   end

   initial begin
      total       = 0;
      bad         = 0;
      stallPct    = 0;
      prevValid   = 1'b0;
      rst_L       = 1'b0;
      i_bit_in    = 1'b0;
      i_bit_valid = 1'b0;
      i_sof       = 1'b0;
      i_msg_ack   = 1'b0;
      payA        = 64'hCAFEBABEDEADBEEF;
      payB        = 64'h0123456789ABCDEF;
      frameA      = buildFrame(payA);
      frameB      = buildFrame(payB);

      $display("[TB] reset values");
      @(negedge clk);
      checkOutput("rstValid", 64'(o_msg_valid), 64'd0);
      checkOutput("rstCrcOk", 64'(o_crc_ok), 64'd0);
      checkOutput("rstMessage", o_message, 64'd0);
      checkOutput("rstBusy", 64'(o_busy), 64'd0);
      checkOutput("rstOverrun", 64'(o_overrun), 64'd0);
      @(negedge clk);
      rst_L = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] good frame");
      applyStimulus(frameA, 80, 1'b1, payA, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      applyAck();

      $display("[TB] payload bit 17 flipped");
      applyStimulus(frameA ^ (80'd1 << 33), 80, 1'b1, payA ^ (64'd1 << 17), 1'b0, 1'b0);
      applyAck();

      $display("[TB] crc bit 5 flipped");
      applyStimulus(frameA ^ (80'd1 << 5), 80, 1'b1, payA, 1'b0, 1'b0);
      applyAck();

      $display("[TB] good frame with stalls");
      stallPct = 30;
      applyStimulus(frameA, 80, 1'b1, payA, 1'b1, 1'b0);
      stallPct = 0;
      applyAck();

      $display("[TB] back-to-back with ack on sof");
      applyStimulus(frameA, 80, 1'b1, payA, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      applyStimulus(frameB, 80, 1'b1, payB, 1'b1, 1'b1);
      checkOutput("b2bOverrun", 64'(o_overrun), 64'd0);
      applyAck();

      $display("[TB] overrun");
      applyStimulus(frameA, 80, 1'b1, payA, 1'b1, 1'b0);
      sendBit(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'(i & 1), 1'b0, 1'b0, 1'b0);
      goIdle();
      checkOutput("overrunSet", 64'(o_overrun), 64'd1);
      checkOutput("overrunValid", 64'(o_msg_valid), 64'd1);
      checkOutput("overrunMessage", o_message, payA);
      checkOutput("overrunBusy", 64'(o_busy), 64'd0);
      applyAck();
      checkOutput("idleAfterAckBusy", 64'(o_busy), 64'd0);
      for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0, 1'b0, 1'b0);
      goIdle();
      checkOutput("idleDiscardBusy", 64'(o_busy), 64'd0);
      checkOutput("idleDiscardValid", 64'(o_msg_valid), 64'd0);

      $display("[TB] abort at bit 40");
      applyStimulus(frameB, 40, 1'b0, 64'd0, 1'b0, 1'b0);
      applyStimulus(frameA, 80, 1'b1, payA, 1'b1, 1'b0);
      applyAck();

      $display("[TB] reset at bit 70");
      applyStimulus(frameB, 70, 1'b0, 64'd0, 1'b0, 1'b0);
      goIdle();
      checkOutput("preResetBusy", 64'(o_busy), 64'd1);
      #2 rst_L = 1'b0;
      #1;
      checkOutput("asyncRstBusy", 64'(o_busy), 64'd0);
      checkOutput("asyncRstValid", 64'(o_msg_valid), 64'd0);
      checkOutput("asyncRstCrcOk", 64'(o_crc_ok), 64'd0);
      checkOutput("asyncRstMessage", o_message, 64'd0);
      checkOutput("asyncRstOverrun", 64'(o_overrun), 64'd0);
      @(negedge clk);
      rst_L = 1'b1;
      for (int i = 70; i < 80; i++) sendBit(frameB[79-i], 1'b0, 1'b0, 1'b0);
      goIdle();
      repeat (3) @(negedge clk);
      checkOutput("postResetValid", 64'(o_msg_valid), 64'd0);
      checkOutput("postResetBusy", 64'(o_busy), 64'd0);

      repeat (2) @(negedge clk);
      checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
